lc3b_mem_arbiter: RTL and testbench
===================================

LC3B_MEM_ARBITER -- requirements
Module: lc3b_mem_arbiter

Interface
- REQ-001: Parameter MAX_WAIT, default 4: number of consecutive data-port grants an instruction-port request may lose before it is granted ahead of data.
- REQ-002: clk  in  1  system clock; all state updates on the rising edge.
- REQ-003: rst_n  in  1  asynchronous, active-low reset.
- REQ-004: i_read  in  1  instruction-fetch read request.
- REQ-005: i_address  in  16  fetch address (lc3b_word).
- REQ-006: i_rdata  out  16  fetch read data.
- REQ-007: i_resp  out  1  fetch completion pulse.
- REQ-008: d_read, d_write  in  1 each  data-port read and write requests.
- REQ-009: d_wmask  in  2  byte write mask (lc3b_mem_wmask).
- REQ-010: d_address, d_wdata  in  16 each  data address and write data.
- REQ-011: d_rdata  out  16  data read result.
- REQ-012: d_resp  out  1  data completion pulse.
- REQ-013: pmem_read, pmem_write  out  1 each  physical memory commands.
- REQ-014: pmem_wmask  out  2; pmem_address, pmem_wdata  out  16 each  physical memory command fields.
- REQ-015: pmem_rdata  in  16; pmem_resp  in  1  physical memory read data and completion.

Function
- REQ-016: The block SHALL implement the FSM states IDLE, I_BUSY and D_BUSY.
- REQ-017: In IDLE, requests SHALL be sampled on each rising edge. A data request (d_read|d_write) SHALL go to D_BUSY. Otherwise i_read SHALL go to I_BUSY. With no request, the FSM SHALL stay in IDLE.
- REQ-018: With i_read and a data request both asserted in IDLE, data SHALL win unless wait_cnt==MAX_WAIT, in which case instruction SHALL win.
- REQ-019: wait_cnt (saturating at MAX_WAIT) SHALL increment on each IDLE grant to data while i_read is high. It SHALL clear on any grant to instruction.
- REQ-020: On grant, the address, wdata, wmask and command type SHALL be latched into registers. pmem_* outputs SHALL be driven only from these registers for the whole transaction; requester input changes mid-transaction SHALL be ignored.
- REQ-021: pmem_read SHALL be 1 in I_BUSY and in a D_BUSY read. pmem_write SHALL be 1 only in a D_BUSY write. Both SHALL be 0 in IDLE.
- REQ-022: If d_read and d_write are both high at grant, the transaction SHALL be treated as a write.
- REQ-023: i_resp SHALL equal pmem_resp & (state==I_BUSY) combinationally. d_resp SHALL equal pmem_resp & (state==D_BUSY) combinationally.
- REQ-024: i_rdata and d_rdata SHALL both pass pmem_rdata through unmodified.
- REQ-025: On a cycle with pmem_resp high in a BUSY state, the FSM SHALL return to IDLE. IDLE SHALL last at least one cycle before the next grant. Requesters deassert in the cycle after resp.
- REQ-026: A request dropped mid-transaction SHALL NOT abort the transaction. The FSM SHALL wait for pmem_resp and still pulse the corresponding resp.
- REQ-027: pmem_resp received in IDLE SHALL be ignored: no resp pulse and no state change.
- REQ-028: Latency SHALL be 1 cycle from request to pmem command assertion, plus the memory latency, to resp.

Reset
- REQ-029: On rst_n low, immediately and without a clock: state=IDLE, wait_cnt=0, latched registers=0, pmem_read=pmem_write=0, i_resp=d_resp=0.
- REQ-030: Reset asserted mid-transaction SHALL abandon the transaction with no resp pulse. Operation SHALL resume in IDLE on the first edge after rst_n rises.

Verification
- REQ-031: i_read=1, i_address=0x0010, memory responds after 3 cycles with 0x1234 -> pmem_read=1 with pmem_address=0x0010 for 3 cycles; i_resp pulses 1 cycle with i_rdata=0x1234; d_resp stays 0.
- REQ-032: d_write=1, d_address=0x0200, d_wdata=0xBEEF, d_wmask=2'b01 -> pmem_write=1 with the same fields until pmem_resp; d_resp pulses once.
- REQ-033: i_read and d_read held continuously with MAX_WAIT=4 -> 4 data grants, then 1 instruction grant, repeating; wait_cnt clears after each instruction grant.
- REQ-034: In D_BUSY, change d_address from 0x0200 to 0x0300 -> pmem_address holds 0x0200 until d_resp.
- REQ-035: Drive rst_n low mid-transaction in I_BUSY -> pmem_read drops the same cycle, no i_resp occurs, and the FSM is in IDLE afterwards.
- REQ-036: pmem_resp pulsed in IDLE -> no i_resp or d_resp, and the state remains IDLE.

Source files
------------

// File: rtl/lc3b_mem_arbiter.sv
// ============================================================================
// Module   : lc3b_mem_arbiter
// Purpose  : Two-port (fetch/data) arbiter onto one physical memory port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lc3b_mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_wmask,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       addr_q;
  logic [15:0]       wdata_q;
  logic [1:0]        wmask_q;
  logic              write_q;
  logic              data_req;
  logic              grant_i;
  logic              grant_d;

  // Fetch only beats data once it has lost MAX_WAIT grants in a row.
  assign data_req = d_read | d_write;
  assign grant_i  = (state == IDLE) & i_read & (~data_req | (wait_cnt == WAIT_LIMIT));
  assign grant_d  = (state == IDLE) & data_req & ~grant_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_next = I_BUSY;
        else if (grant_d) state_next = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        wait_cnt <= '0;
        addr_q   <= i_address;
        wdata_q  <= '0;
        wmask_q  <= '0;
        write_q  <= 1'b0;
      end else if (grant_d) begin
        if (i_read && (wait_cnt != WAIT_LIMIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        wmask_q <= d_wmask;
        // A simultaneous read+write request is carried out as a write.
        write_q <= d_write;
      end
    end
  end

  assign pmem_read    = (state == I_BUSY) | ((state == D_BUSY) & ~write_q);
  assign pmem_write   = (state == D_BUSY) & write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_wmask   = wmask_q;

  assign i_resp  = pmem_resp & (state == I_BUSY);
  assign d_resp  = pmem_resp & (state == D_BUSY);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_lc3b_mem_arbiter.sv
// ============================================================================
// Module   : tb_lc3b_mem_arbiter
// Purpose  : Directed bench with a transaction-level reference for the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lc3b_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_read = 1'b0;
  logic [15:0] i_address = 16'h0;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [1:0]  d_wmask = 2'b00;
  logic [15:0] d_address = 16'h0;
  logic [15:0] d_wdata = 16'h0;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata = 16'h0;
  logic        pmem_resp;
  logic        auto_resp = 1'b0;
  logic        inject_resp = 1'b0;

  assign pmem_resp = auto_resp | inject_resp;

  always #5 clk = ~clk;

  lc3b_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'h1234;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // Memory model: responds on the mem_lat-th cycle a command is held.
  int mem_lat = 3;
  int lat_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (pmem_read || pmem_write) begin
      lat_cnt++;
      auto_resp  = (lat_cnt == mem_lat);
      pmem_rdata = mem_word(pmem_address);
    end else begin
      lat_cnt   = 0;
      auto_resp = 1'b0;
    end
  end

  // Reference: which transaction (none / fetch / data) owns memory, and its fields.
  int          m_owner = 0;   // 0 none, 1 fetch, 2 data
  int          m_losses = 0;
  logic [15:0] m_addr = 16'h0;
  logic [15:0] m_wdata = 16'h0;
  logic [1:0]  m_wmask = 2'b00;
  bit          m_write = 1'b0;
  bit          m_dreq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_losses = 0; m_addr = 16'h0; m_wdata = 16'h0; m_wmask = 2'b00; m_write = 1'b0;
    end else if (m_owner == 0) begin
      m_dreq = d_read || d_write;
      if (i_read && (!m_dreq || m_losses >= MAX_WAIT)) begin
        m_owner = 1; m_losses = 0; m_addr = i_address; m_write = 1'b0;
      end else if (m_dreq) begin
        m_owner = 2;
        if (i_read) m_losses = (m_losses + 1 > MAX_WAIT) ? MAX_WAIT : m_losses + 1;
        m_addr = d_address; m_wdata = d_wdata; m_wmask = d_wmask; m_write = d_write;
      end
    end else if (pmem_resp) begin
      m_owner = 0;
    end
  end

  int  cmd_cycles = 0;
  int  i_resp_cnt = 0;
  int  d_resp_cnt = 0;
  bit  cmd_prev = 1'b0;
  byte glog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_pmem_read", pmem_read, 0);
      chk("rst_pmem_write", pmem_write, 0);
      chk("rst_i_resp", i_resp, 0);
      chk("rst_d_resp", d_resp, 0);
      chk("rst_pmem_address", pmem_address, 0);
    end else begin
      chk("pmem_read", pmem_read, (m_owner == 1) || (m_owner == 2 && !m_write));
      chk("pmem_write", pmem_write, (m_owner == 2) && m_write);
      chk("i_resp", i_resp, pmem_resp && (m_owner == 1));
      chk("d_resp", d_resp, pmem_resp && (m_owner == 2));
      chk("i_rdata", i_rdata, pmem_rdata);
      chk("d_rdata", d_rdata, pmem_rdata);
      if (m_owner != 0) chk("pmem_address", pmem_address, m_addr);
      if (m_owner == 2 && m_write) begin
        chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("pmem_wmask", pmem_wmask, m_wmask);
      end
    end
    if (pmem_read || pmem_write) cmd_cycles++;
    if (i_resp) i_resp_cnt++;
    if (d_resp) d_resp_cnt++;
    if ((pmem_read || pmem_write) && !cmd_prev) glog.push_back((pmem_address == 16'h0040) ? 8'h49 : 8'h44);
    cmd_prev = pmem_read || pmem_write;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_resp(input bit want_i, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (want_i ? i_resp : d_resp) seen = 1'b1;
    end
    chk({name, "_resp_seen"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int    c0, i0, d0, g0;
  string exp_pat = "DDDDIDDDDI";

  initial begin
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    chk("reset_state_read", pmem_read, 0);
    chk("reset_state_i_resp", i_resp, 0);

    // Fetch, 3-cycle memory
    c0 = cmd_cycles; i0 = i_resp_cnt; d0 = d_resp_cnt;
    mem_lat = 3; i_address = 16'h0010; i_read = 1'b1;
    tick;
    chk("fetch_latency", pmem_read, 1);
    wait_resp(1, "fetch");
    chk("fetch_rdata", i_rdata, 16'h1234);
    chk("fetch_addr", pmem_address, 16'h0010);
    tick; i_read = 1'b0; tick;
    chk("fetch_cmd_cycles", cmd_cycles - c0, 3);
    chk("fetch_i_pulses", i_resp_cnt - i0, 1);
    chk("fetch_no_d_resp", d_resp_cnt - d0, 0);

    // Byte write
    c0 = cmd_cycles; i0 = i_resp_cnt; d0 = d_resp_cnt;
    mem_lat = 2; d_address = 16'h0200; d_wdata = 16'hBEEF; d_wmask = 2'b01; d_write = 1'b1;
    wait_resp(0, "write");
    chk("write_cmd", pmem_write, 1);
    chk("write_addr", pmem_address, 16'h0200);
    chk("write_wdata", pmem_wdata, 16'hBEEF);
    chk("write_wmask", pmem_wmask, 2'b01);
    tick; d_write = 1'b0; tick;
    chk("write_cmd_cycles", cmd_cycles - c0, 2);
    chk("write_d_pulses", d_resp_cnt - d0, 1);
    chk("write_no_i_resp", i_resp_cnt - i0, 0);

    // Address change mid-transaction is ignored
    mem_lat = 4; d_address = 16'h0200; d_read = 1'b1;
    tick; tick;
    d_address = 16'h0300;
    wait_resp(0, "hold");
    chk("hold_addr", pmem_address, 16'h0200);
    chk("hold_rdata", d_rdata, 16'h5A58);
    tick; d_read = 1'b0; tick;

    // Read and write together -> write
    mem_lat = 1; d_address = 16'h0123; d_wdata = 16'h5555; d_wmask = 2'b11;
    d_read = 1'b1; d_write = 1'b1;
    tick;
    chk("rw_is_write", pmem_write, 1);
    chk("rw_not_read", pmem_read, 0);
    wait_resp(0, "rw");
    tick; d_read = 1'b0; d_write = 1'b0; tick;

    // Fetch request dropped mid-transaction still completes
    mem_lat = 4; i_address = 16'h0020; i_read = 1'b1;
    tick; tick;
    i_read = 1'b0;
    wait_resp(1, "drop");
    chk("drop_rdata", i_rdata, 16'h7A5A);
    tick; tick;

    // Stray response while idle
    inject_resp = 1'b1;
    @(negedge clk); #1;
    chk("idle_resp_i", i_resp, 0);
    chk("idle_resp_d", d_resp, 0);
    tick;
    inject_resp = 1'b0;
    chk("idle_stays_read", pmem_read, 0);
    chk("idle_stays_write", pmem_write, 0);
    tick;

    // Starvation bound: both ports held continuously
    g0 = glog.size();
    mem_lat = 1; i_address = 16'h0040; d_address = 16'h0400;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 200 && (glog.size() - g0) < 10; k++) tick;
    i_read = 1'b0; d_read = 1'b0;
    chk("starve_grant_count", ((glog.size() - g0) >= 10) ? 1 : 0, 1);
    if ((glog.size() - g0) >= 10)
      for (int k = 0; k < 10; k++) chk($sformatf("starve_grant%0d", k), glog[g0 + k], exp_pat[k]);
    repeat (4) tick;

    // Asynchronous reset during a fetch
    mem_lat = 6; i_address = 16'h0050; i_read = 1'b1;
    tick; tick;
    chk("pre_rst_busy", pmem_read, 1);
    i0 = i_resp_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_async_read", pmem_read, 0);
    chk("rst_async_i_resp", i_resp, 0);
    i_read = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_idle", pmem_read, 0);
    chk("post_rst_no_i_resp", i_resp_cnt - i0, 0);

    // Normal operation resumes
    mem_lat = 2; i_address = 16'h0010; i_read = 1'b1;
    wait_resp(1, "resume");
    chk("resume_rdata", i_rdata, 16'h1234);
    tick; i_read = 1'b0; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
